pb_preload_arbiter: RTL

//  Shares one preload write port into the SoC memory map between several preload agents:
//  the JTAG DMI bridge, the serial-link bridge and the UART debug loader.

---
 rtl/pb_preload_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/pb_preload_arbiter.sv
// Shares one preload write port between several preload agents. Bursts are granted
// round-robin and locked until last, runaway bursts are capped, and EOC writes are snooped.
module pb_preload_arbiter #(
    parameter int                   NumReq    = 3,
    parameter int                   AddrWidth = 48,
    parameter int                   DataWidth = 64,
    parameter int                   MaxBurst  = 256,
    parameter logic [AddrWidth-1:0] EocAddr   = AddrWidth'(48'h0300_0008)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_data_i,
    input  logic [NumReq-1:0]             req_last_i,
    output logic                          mem_valid_o,
    input  logic                          mem_ready_i,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth-1:0]          mem_data_o,
    output logic                          mem_last_o,
    output logic [$clog2(NumReq)-1:0]     mem_src_o,
    output logic                          busy_o,
    output logic                          err_o,
    output logic                          eoc_o,
    output logic [31:0]                   exit_code_o
);
    localparam int SrcW = $clog2(NumReq);
    localparam int CntW = $clog2(MaxBurst + 1);

    typedef enum logic {IDLE, BURST} state_e;

    state_e              state_q;
    logic [SrcW-1:0]     owner_q;
    logic [SrcW-1:0]     rr_ptr_q;
    logic [CntW-1:0]     beat_cnt_q;
    logic                err_q;
    logic                eoc_q;
    logic [31:0]         exit_code_q;

    logic [SrcW-1:0]     owner_d;
    logic                grant_found;
    logic                burst;
    logic                cap_beat;
    logic                hs;

    logic [AddrWidth-1:0] addr_arr [NumReq];
    logic [DataWidth-1:0] data_arr [NumReq];

    for (genvar gi = 0; gi < NumReq; gi++) begin : g_slice
        assign addr_arr[gi]    = req_addr_i[gi*AddrWidth +: AddrWidth];
        assign data_arr[gi]    = req_data_i[gi*DataWidth +: DataWidth];
        assign req_ready_o[gi] = burst && (owner_q == SrcW'(gi)) && mem_ready_i;
    end

    function automatic logic [SrcW-1:0] rr_index(input logic [SrcW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NumReq) s = s - NumReq;
        return SrcW'(s);
    endfunction

    // Scan downwards so the candidate closest to rr_ptr is assigned last and wins.
    always_comb begin
        grant_found = 1'b0;
        owner_d     = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            if (req_valid_i[rr_index(rr_ptr_q, k)]) begin
                grant_found = 1'b1;
                owner_d     = rr_index(rr_ptr_q, k);
            end
        end
    end

    assign burst       = (state_q == BURST);
    assign cap_beat    = (beat_cnt_q == CntW'(MaxBurst - 1));
    assign mem_valid_o = burst && req_valid_i[owner_q];
    assign mem_addr_o  = burst ? addr_arr[owner_q] : '0;
    assign mem_data_o  = burst ? data_arr[owner_q] : '0;
    assign mem_last_o  = burst && (req_last_i[owner_q] || cap_beat);
    assign mem_src_o   = burst ? owner_q : '0;
    assign busy_o      = burst;
    assign err_o       = err_q;
    assign eoc_o       = eoc_q;
    assign exit_code_o = exit_code_q;
    assign hs          = mem_valid_o && mem_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            beat_cnt_q  <= '0;
            err_q       <= 1'b0;
            eoc_q       <= 1'b0;
            exit_code_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_found) begin
                        owner_q <= owner_d;
                        state_q <= BURST;
                    end
                end
                BURST: begin
                    if (hs) begin
                        beat_cnt_q <= beat_cnt_q + CntW'(1);
                        if (cap_beat && !req_last_i[owner_q]) err_q <= 1'b1;
                        if (mem_last_o) begin
                            state_q    <= IDLE;
                            rr_ptr_q   <= (owner_q == SrcW'(NumReq - 1)) ? '0 : owner_q + SrcW'(1);
                            beat_cnt_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (hs && (mem_addr_o == EocAddr) && mem_data_o[0]) begin
                eoc_q       <= 1'b1;
                exit_code_q <= {1'b0, mem_data_o[31:1]};
            end
        end
    end
endmodule
